// File: rtl/mips_data_bridge_if.sv
// Signal bundle between the Harvard CPU data port, the stalling bridge and the data memory bus.
// The master view belongs to the bridge. The slave view belongs to the CPU and memory environment.
interface mips_data_bridge_if;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;

  modport master (
    input  cpu_data_address, cpu_data_read, cpu_data_write, cpu_data_writedata,
    output cpu_data_readdata, cpu_clk_enable,
    output bus_address, bus_read, bus_write, bus_writedata, bus_error,
    input  bus_waitrequest, bus_readdata
  );

  modport slave (
    output cpu_data_address, cpu_data_read, cpu_data_write, cpu_data_writedata,
    input  cpu_data_readdata, cpu_clk_enable,
    input  bus_address, bus_read, bus_write, bus_writedata, bus_error,
    output bus_waitrequest, bus_readdata
  );
endinterface

// File: rtl/mips_data_bridge.sv
// Stalls the CPU through clk_enable while a load or store is outstanding on a waitrequest bus.
// Define MIPS_DATA_BRIDGE_TIMEOUT_EN to abort requests held for TIMEOUT_CYCLES and raise a sticky bus_error.
module mips_data_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
  input logic                 clk,
  input logic                 reset,
  mips_data_bridge_if.master  dif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        clk_en;

`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
  localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    read_d  = read_q;
    write_d = write_q;
    clk_en  = 1'b1;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        clk_en = !(dif.cpu_data_read || dif.cpu_data_write);
        if (dif.cpu_data_read || dif.cpu_data_write) begin
          addr_d  = dif.cpu_data_address;
          wdata_d = dif.cpu_data_writedata;
          write_d = dif.cpu_data_write;
          // A store wins over a simultaneous load, and the load sees zero.
          read_d  = dif.cpu_data_read && !dif.cpu_data_write;
          if (dif.cpu_data_read && dif.cpu_data_write) rdata_d = '0;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        clk_en = 1'b0;
        if (!dif.bus_waitrequest) begin
          if (read_q) rdata_d = dif.bus_readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
        end
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
        else if (({1'b0, cnt_q} + 17'd1) >= TimeoutLimit) begin
          if (read_q) rdata_d = ERR_READDATA;
          read_d  = 1'b0;
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        clk_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the CPU enabled so its own reset is clocked in.
  assign dif.cpu_clk_enable    = !reset || clk_en;
  assign dif.cpu_data_readdata = rdata_q;
  assign dif.bus_address       = addr_q;
  assign dif.bus_writedata     = wdata_q;
  assign dif.bus_read          = read_q;
  assign dif.bus_write         = write_q;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
  assign dif.bus_error         = err_q;
`else
  assign dif.bus_error         = 1'b0;
`endif

endmodule

// File: tb/tb_mips_data_bridge.sv
// Randomized self-checking bench for mips_data_bridge against a per-access stall/result model.
// Honours MIPS_DATA_BRIDGE_TIMEOUT_EN to also exercise the abort path with TIMEOUT_CYCLES=4.
module tb_mips_data_bridge;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] ERRD    = 32'hDEADBEEF;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_data_bridge_if dif();

  mips_data_bridge #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_READDATA(ERRD)) dut (
    .clk(clk),
    .reset(reset),
    .dif(dif.master)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] modelRdata = '0;
  logic        modelErr = 1'b0;

  // Reference model: cost and effect of one CPU instruction given how long the slave stalls.
  task automatic modelAccess(input logic rd, input logic wr, input logic [31:0] rbus,
                             input int waits, output int expStalls, output int expStrobes,
                             output int expFirst);
    bit mem = rd || wr;
    bit aborted = TO_EN && mem && (waits >= TIMEOUT);
    expFirst = mem ? 1 : -1;
    if (!mem) begin
      expStalls = 0; expStrobes = 0;
    end else if (aborted) begin
      expStrobes = TIMEOUT; expStalls = TIMEOUT + 1; modelErr = 1'b1;
      if (rd && wr) modelRdata = '0;
      else if (rd) modelRdata = ERRD;
    end else begin
      expStrobes = waits + 1; expStalls = waits + 2;
      if (rd && wr) modelRdata = '0;
      else if (rd) modelRdata = rbus;
    end
  endtask

  // Plays CPU and memory slave for one instruction; called just after a rising edge.
  task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rbus, input int waits,
                           output int stalls, output int strobes, output int firstStrobe,
                           output logic [31:0] rdOut, output logic shapeOk, output logic done);
    stalls = 0; strobes = 0; firstStrobe = -1; rdOut = '0; shapeOk = 1'b1; done = 1'b0;
    dif.cpu_data_read = rd;
    dif.cpu_data_write = wr;
    dif.cpu_data_address = addr;
    dif.cpu_data_writedata = wdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      dif.bus_waitrequest = 1'b1;
      dif.bus_readdata = $urandom;
      if (dif.bus_read || dif.bus_write) begin
        if (firstStrobe < 0) firstStrobe = cyc;
        if (firstStrobe + strobes != cyc) shapeOk = 1'b0;
        if (dif.bus_address !== addr || dif.bus_read !== (rd && !wr) || dif.bus_write !== wr ||
            (wr && dif.bus_writedata !== wdata)) shapeOk = 1'b0;
        if (strobes >= waits) begin
          dif.bus_waitrequest = 1'b0;
          dif.bus_readdata = rbus;
        end
        strobes++;
      end
      if (dif.cpu_clk_enable === 1'b1) begin
        done = 1'b1;
        rdOut = dif.cpu_data_readdata;
        if (dif.bus_read || dif.bus_write) shapeOk = 1'b0;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    dif.cpu_data_read = 1'b0;
    dif.cpu_data_write = 1'b0;
  endtask

  task automatic test_reset;
    dif.cpu_data_read = 1'b1;
    #12;
    vectors++; if (dif.cpu_clk_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_clk_enable: got %b, expected 1", dif.cpu_clk_enable); end
    vectors++; if (dif.bus_read !== 1'b0 || dif.bus_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobes: got read=%b write=%b, expected 0 0", dif.bus_read, dif.bus_write); end
    vectors++; if (dif.bus_address !== 32'h0 || dif.bus_writedata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_bus_regs: got addr=%h wdata=%h, expected 0 0", dif.bus_address, dif.bus_writedata); end
    vectors++; if (dif.cpu_data_readdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_readdata: got %h, expected 0", dif.cpu_data_readdata); end
    vectors++; if (dif.bus_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %b, expected 0", dif.bus_error); end
    dif.cpu_data_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_non_memory;
    for (int i = 0; i < 20; i++) begin
      dif.cpu_data_address = $urandom;
      dif.cpu_data_writedata = $urandom;
      @(negedge clk);
      vectors++;
      if (dif.cpu_clk_enable !== 1'b1 || dif.bus_read !== 1'b0 || dif.bus_write !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL nonmem_cycle%0d: got en=%b rd=%b wr=%b, expected 1 0 0", i, dif.cpu_clk_enable, dif.bus_read, dif.bus_write);
      end
      @(posedge clk); #1;
    end
    dif.cpu_data_read = 1'b1;
    #1;
    vectors++; if (dif.cpu_clk_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_comb_stall: got %b, expected 0", dif.cpu_clk_enable); end
    dif.cpu_data_read = 1'b0;
    #1;
    vectors++; if (dif.cpu_clk_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_comb_release: got %b, expected 1", dif.cpu_clk_enable); end
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    int st, sb, fs, es, eb, ef; logic [31:0] rdo; logic ok, dn;
    modelAccess(1'b1, 1'b0, 32'h12345678, 0, es, eb, ef);
    runAccess(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h12345678, 0, st, sb, fs, rdo, ok, dn);
    vectors++; if (!dn) begin miscompares++; $display("[TB] FAIL load_done: got timeout, expected completion"); end
    vectors++; if (st !== es || sb !== eb) begin miscompares++; $display("[TB] FAIL load_timing: got stalls=%0d strobes=%0d, expected %0d %0d", st, sb, es, eb); end
    vectors++; if (fs !== ef || !ok) begin miscompares++; $display("[TB] FAIL load_shape: got first=%0d ok=%b, expected %0d 1", fs, ok, ef); end
    vectors++; if (rdo !== modelRdata) begin miscompares++; $display("[TB] FAIL load_data: got %h, expected %h", rdo, modelRdata); end
  endtask

  task automatic test_store_wait;
    int st, sb, fs, es, eb, ef; logic [31:0] rdo; logic ok, dn;
    modelAccess(1'b0, 1'b1, 32'h0, 3, es, eb, ef);
    runAccess(1'b0, 1'b1, 32'h0000_1004, 32'hCAFEF00D, 32'h0, 3, st, sb, fs, rdo, ok, dn);
    vectors++; if (!dn) begin miscompares++; $display("[TB] FAIL store_done: got timeout, expected completion"); end
    vectors++; if (st !== es || sb !== eb) begin miscompares++; $display("[TB] FAIL store_timing: got stalls=%0d strobes=%0d, expected %0d %0d", st, sb, es, eb); end
    vectors++; if (fs !== ef || !ok) begin miscompares++; $display("[TB] FAIL store_shape: got first=%0d ok=%b, expected %0d 1", fs, ok, ef); end
    vectors++; if (rdo !== modelRdata) begin miscompares++; $display("[TB] FAIL store_readdata: got %h, expected %h", rdo, modelRdata); end
  endtask

  // Back-to-back, simultaneous and random accesses share one scenario shape: a list of instructions.
  task automatic runSequence(input string name, input int count, input bit randomKind,
                             input logic rd0, input logic wr0);
    int st, sb, fs, es, eb, ef, waits; logic [31:0] rdo, rbus, addr, wdata; logic ok, dn, rd, wr;
    for (int i = 0; i < count; i++) begin
      rd = randomKind ? logic'($urandom_range(0, 1)) : (i == 0 ? rd0 : !rd0);
      wr = randomKind ? logic'($urandom_range(0, 1)) : (i == 0 ? wr0 : 1'b1);
      waits = $urandom_range(0, 5);
      rbus = $urandom; addr = $urandom; wdata = $urandom;
      modelAccess(rd, wr, rbus, waits, es, eb, ef);
      runAccess(rd, wr, addr, wdata, rbus, waits, st, sb, fs, rdo, ok, dn);
      vectors++;
      if (!dn || st !== es || sb !== eb) begin
        miscompares++;
        $display("[TB] FAIL %s_timing%0d: got done=%b stalls=%0d strobes=%0d, expected 1 %0d %0d (rd=%b wr=%b waits=%0d)", name, i, dn, st, sb, es, eb, rd, wr, waits);
      end
      vectors++;
      if (fs !== ef || !ok) begin
        miscompares++;
        $display("[TB] FAIL %s_shape%0d: got first=%0d ok=%b, expected %0d 1", name, i, fs, ok, ef);
      end
      vectors++;
      if (rdo !== modelRdata || dif.bus_error !== modelErr) begin
        miscompares++;
        $display("[TB] FAIL %s_result%0d: got data=%h err=%b, expected %h %b", name, i, rdo, dif.bus_error, modelRdata, modelErr);
      end
    end
  endtask

  task automatic test_back_to_back;
    runSequence("b2b", 2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous;
    runSequence("simul", 1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    runSequence("rand", 30, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int st, sb, fs, es, eb, ef; logic [31:0] rdo; logic ok, dn;
    if (TO_EN) begin
      modelAccess(1'b1, 1'b0, 32'h0, 1000, es, eb, ef);
      runAccess(1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 1000, st, sb, fs, rdo, ok, dn);
      vectors++; if (!dn || st !== es || sb !== eb) begin miscompares++; $display("[TB] FAIL timeout_timing: got done=%b stalls=%0d strobes=%0d, expected 1 %0d %0d", dn, st, sb, es, eb); end
      vectors++; if (rdo !== modelRdata) begin miscompares++; $display("[TB] FAIL timeout_data: got %h, expected %h", rdo, modelRdata); end
      vectors++; if (dif.bus_error !== modelErr) begin miscompares++; $display("[TB] FAIL timeout_error: got %b, expected %b", dif.bus_error, modelErr); end
      modelAccess(1'b1, 1'b0, 32'h0BADF00D, 0, es, eb, ef);
      runAccess(1'b1, 1'b0, 32'h0000_2004, 32'h0, 32'h0BADF00D, 0, st, sb, fs, rdo, ok, dn);
      vectors++; if (dif.bus_error !== modelErr || rdo !== modelRdata) begin miscompares++; $display("[TB] FAIL timeout_sticky: got err=%b data=%h, expected %b %h", dif.bus_error, rdo, modelErr, modelRdata); end
    end
  endtask

  task automatic test_reset_mid_req;
    dif.cpu_data_read = 1'b1;
    dif.cpu_data_address = 32'h0000_3000;
    dif.bus_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (dif.bus_read !== 1'b1) begin miscompares++; $display("[TB] FAIL midreq_pending: got bus_read=%b, expected 1", dif.bus_read); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (dif.bus_read !== 1'b0 || dif.cpu_clk_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL midreq_async: got rd=%b en=%b, expected 0 1", dif.bus_read, dif.cpu_clk_enable); end
    modelRdata = '0;
    modelErr = 1'b0;
    dif.cpu_data_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (dif.bus_read !== 1'b0 || dif.bus_write !== 1'b0 || dif.cpu_clk_enable !== 1'b1 ||
          dif.bus_error !== modelErr || dif.cpu_data_readdata !== modelRdata) begin
        miscompares++;
        $display("[TB] FAIL midreq_after%0d: got rd=%b wr=%b en=%b err=%b data=%h, expected 0 0 1 0 0", i, dif.bus_read, dif.bus_write, dif.cpu_clk_enable, dif.bus_error, dif.cpu_data_readdata);
      end
    end
    dif.cpu_data_read = 1'b1;
    #1;
    vectors++; if (dif.cpu_clk_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL midreq_idle: got en=%b, expected 0", dif.cpu_clk_enable); end
    dif.cpu_data_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    dif.cpu_data_address = '0;
    dif.cpu_data_read = 1'b0;
    dif.cpu_data_write = 1'b0;
    dif.cpu_data_writedata = '0;
    dif.bus_waitrequest = 1'b1;
    dif.bus_readdata = '0;
    test_reset();
    test_non_memory();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_simultaneous();
    test_timeout();
    test_random();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
